bitwise_logic_unit: RTL and testbench

Parametrised, pipelined bitwise logic unit for the ALU datapath. Performs one of eight selectable bitwise operations on two WIDTH-bit operands, including two multi-beat accumulate modes (OR-reduce, AND-reduce) that fold a burst of operand pairs into one result. Results leave through a single registered output stage with a valid/ready handshake, so the block can sit between the operand-fetch stage and the writeback mux under backpressure.

---
 rtl/bitwise_logic_unit.sv | 167 ++++++++++++++++
 tb/tb_bitwise_logic_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : bitwise_logic_unit
// Description : Pipelined bitwise logic unit for the ALU datapath. Applies
//               one of eight bitwise operations to two WIDTH-bit operands.
//               Two accumulate modes (OR-reduce, AND-reduce) fold a burst of
//               operand pairs into a single result. Results leave through one
//               registered output stage with a valid/ready handshake.
// Ports       : clock, reset (async, active-low)
//               in_valid/in_ready             - operand beat handshake
//               data_operandA/B, ctrl_op      - operands, operation select
//               in_last                       - last beat of accumulate burst
//               out_valid/out_ready           - result handshake
//               result, result_zero           - result and its zero flag
//               result_beats                  - beats folded into result
// Revision    : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [2:0]       ctrl_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_zero,
    output logic [CNT_W-1:0] result_beats
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_accum = 1'b1;

    localparam logic [2:0] c_op_and  = 3'b000;
    localparam logic [2:0] c_op_or   = 3'b001;
    localparam logic [2:0] c_op_xor  = 3'b010;
    localparam logic [2:0] c_op_nor  = 3'b011;
    localparam logic [2:0] c_op_andn = 3'b100;
    localparam logic [2:0] c_op_orn  = 3'b101;
    localparam logic [2:0] c_op_acco = 3'b110;
    localparam logic [2:0] c_op_acca = 3'b111;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [0:0]       r_state;
    logic             r_mode_and;   // latched accumulate mode: 0 = OR, 1 = AND
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_result_zero;
    logic [CNT_W-1:0] r_result_beats;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_acc_op;
    logic [WIDTH-1:0] w_idle_term;
    logic [WIDTH-1:0] w_burst_term;
    logic [WIDTH-1:0] w_folded;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_produce;
    logic             w_start_burst;
    logic [WIDTH-1:0] w_load_value;
    logic [CNT_W-1:0] w_load_beats;

    // Ready depends only on the output stage so upstream never sees a
    // combinational path from its own valid/data back to ready.
    assign w_in_ready  = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_is_acc_op = (ctrl_op == c_op_acco) || (ctrl_op == c_op_acca);

    always_comb begin
        w_idle_term = '0;
        case (ctrl_op)
            c_op_and:  w_idle_term = data_operandA & data_operandB;
            c_op_or:   w_idle_term = data_operandA | data_operandB;
            c_op_xor:  w_idle_term = data_operandA ^ data_operandB;
            c_op_nor:  w_idle_term = ~(data_operandA | data_operandB);
            c_op_andn: w_idle_term = data_operandA & ~data_operandB;
            c_op_orn:  w_idle_term = data_operandA | ~data_operandB;
            c_op_acco: w_idle_term = data_operandA | data_operandB;
            c_op_acca: w_idle_term = data_operandA & data_operandB;
            default:   w_idle_term = '0;
        endcase
    end

    // Inside a burst the latched mode decides the term; ctrl_op is ignored.
    assign w_burst_term = r_mode_and ? (data_operandA & data_operandB)
                                     : (data_operandA | data_operandB);
    assign w_folded     = r_mode_and ? (r_acc & w_burst_term)
                                     : (r_acc | w_burst_term);

    // Saturating beat count; the fold itself keeps running past saturation.
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    always_comb begin
        w_produce     = 1'b0;
        w_start_burst = 1'b0;
        w_load_value  = w_idle_term;
        w_load_beats  = c_cnt_one;
        if (r_state == c_st_idle) begin
            w_produce     = w_accept && (!w_is_acc_op || in_last);
            w_start_burst = w_accept && w_is_acc_op && !in_last;
        end else begin
            w_produce    = w_accept && in_last;
            w_load_value = w_folded;
            w_load_beats = w_cnt_inc;
        end
    end

    // Burst control
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_mode_and <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if (r_state == c_st_idle) begin
            if (w_start_burst) begin
                r_state    <= c_st_accum;
                r_mode_and <= ctrl_op[0];
                r_acc      <= w_idle_term;
                r_cnt      <= c_cnt_one;
            end
        end else if (w_accept) begin
            if (in_last) begin
                r_state <= c_st_idle;
            end else begin
                r_acc <= w_folded;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Output register stage. A new result can load in the same edge the old
    // one retires because w_produce already implies out_ready when full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_result_zero  <= 1'b0;
            r_result_beats <= '0;
        end else if (w_produce) begin
            r_out_valid    <= 1'b1;
            r_result       <= w_load_value;
            r_result_zero  <= (w_load_value == '0);
            r_result_beats <= w_load_beats;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign result_zero  = r_result_zero;
    assign result_beats = r_result_beats;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitwise_logic_unit
// Description : Self-checking bench for bitwise_logic_unit. Two instances
//               share stimulus: one with CNT_W = 8, one with CNT_W = 2 to
//               exercise beat-count saturation. A queue-based burst model
//               provides expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [2:0]    ctrl_op;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;

    logic          in_ready,  out_valid,  result_zero;
    logic [W-1:0]  result;
    logic [7:0]    result_beats;
    logic          in_ready2, out_valid2, result_zero2;
    logic [W-1:0]  result2;
    logic [1:0]    result_beats2;

    always #5 clock = ~clock;

    bitwise_logic_unit #(.WIDTH(W), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_operandA(op_a), .data_operandB(op_b), .ctrl_op(ctrl_op),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_zero(result_zero), .result_beats(result_beats)
    );

    bitwise_logic_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .data_operandA(op_a), .data_operandB(op_b), .ctrl_op(ctrl_op),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .result_zero(result_zero2), .result_beats(result_beats2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_valid;
    logic [W-1:0] m_result;
    int           m_beats;
    bit           m_busy;
    bit           m_mode_and;
    logic [W-1:0] m_q[$];

    function automatic logic [W-1:0] term(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x | y);
            3'd4:    return x & ~y;
            3'd5:    return x | ~y;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_result = '0;
        m_beats  = 0;
        m_busy   = 0;
        m_q.delete();
    endtask

    // Applies the inputs present at a clock edge to the model.
    task automatic model_edge();
        bit           rdy;
        bit           acc;
        bit           prod;
        logic [W-1:0] val;
        int           beats;
        rdy   = !m_valid || out_ready;
        acc   = in_valid && rdy && (reset === 1'b1);
        prod  = 0;
        val   = '0;
        beats = 0;
        if (acc) begin
            if (!m_busy) begin
                if (ctrl_op[2:1] != 2'b11 || in_last) begin
                    prod  = 1;
                    val   = term(ctrl_op, op_a, op_b);
                    beats = 1;
                end else begin
                    m_busy     = 1;
                    m_mode_and = ctrl_op[0];
                    m_q.delete();
                    m_q.push_back(term(ctrl_op, op_a, op_b));
                end
            end else begin
                m_q.push_back(m_mode_and ? (op_a & op_b) : (op_a | op_b));
                if (in_last) begin
                    val = m_mode_and ? '1 : '0;
                    foreach (m_q[i]) val = m_mode_and ? (val & m_q[i]) : (val | m_q[i]);
                    beats  = m_q.size();
                    prod   = 1;
                    m_busy = 0;
                    m_q.delete();
                end
            end
        end
        if (prod) begin
            m_valid  = 1;
            m_result = val;
            m_beats  = beats;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        check("out_valid_sat", out_valid2, m_valid);
        if (m_valid) begin
            check("result", result, m_result);
            check("result_zero", result_zero, m_result == '0);
            check("result_beats", result_beats, (m_beats > 255) ? 255 : m_beats);
            check("result_sat", result2, m_result);
            check("result_beats_sat", result_beats2, (m_beats > 3) ? 3 : m_beats);
        end
    endtask

    // One clock cycle: drive, check ready before the edge, check outputs after.
    task automatic cycle(input bit iv, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit last, input bit ordy);
        in_valid  = iv;
        ctrl_op   = op;
        op_a      = a;
        op_b      = b;
        in_last   = last;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !m_valid || ordy);
        check("in_ready_sat", in_ready2, !m_valid || ordy);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] held;

        tbl[0] = '{3'd0, 32'h00F0_1234};
        tbl[1] = '{3'd1, 32'hFFF0_FFFF};
        tbl[2] = '{3'd2, 32'hFF00_EDCB};
        tbl[3] = '{3'd3, 32'h000F_0000};
        tbl[4] = '{3'd4, 32'hF000_0000};
        tbl[5] = '{3'd5, 32'hF0FF_1234};

        // Reset with random inputs toggling
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            ctrl_op   = 3'($urandom);
            op_a      = $urandom;
            op_b      = $urandom;
            in_last   = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clock);
            #1;
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_result", result, '0);
            check("rst_zero", result_zero, 1'b0);
            check("rst_beats", result_beats, '0);
            check("rst_in_ready", in_ready, 1'b1);
        end
        reset = 1'b1;

        // Idle after release
        cycle(0, 3'd0, '0, '0, 0, 1);
        cycle(0, 3'd6, '1, '1, 0, 0);
        check("idle_result", result, '0);
        check("idle_beats", result_beats, '0);

        // All simple ops back-to-back
        for (int i = 0; i < 6; i++) begin
            cycle(1, tbl[i].op, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 1);
            check("simple_op_result", result, tbl[i].exp);
            check("simple_op_beats", result_beats, 8'd1);
            check("simple_op_zero", result_zero, 1'b0);
        end
        cycle(0, 3'd0, '0, '0, 0, 1);

        // ACC_OR burst of 4, ctrl_op changed mid-burst
        cycle(1, 3'd6, 32'h1, 32'h0, 0, 1);
        cycle(1, 3'd0, 32'h2, 32'h0, 0, 1);
        cycle(1, 3'd0, 32'h0, 32'h4, 0, 1);
        check("accor_no_early_out", out_valid, 1'b0);
        cycle(1, 3'd0, 32'h8, 32'h0, 1, 1);
        check("accor_valid", out_valid, 1'b1);
        check("accor_result", result, 32'h0000_000F);
        check("accor_beats", result_beats, 8'd4);

        // ACC_AND to zero
        cycle(1, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_00FF, 0, 1);
        cycle(1, 3'd7, 32'h0000_FF00, 32'hFFFF_FFFF, 1, 1);
        check("accand_result", result, '0);
        check("accand_zero", result_zero, 1'b1);
        check("accand_beats", result_beats, 8'd2);

        // Backpressure with a beat offered the whole time
        cycle(1, 3'd1, 32'h11, 32'h22, 0, 1);
        held = result;
        check("bp_first", held, 32'h33);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 3'd2, 32'h5, 32'h3, 0, 0);
            check("bp_hold_result", result, 32'h33);
            check("bp_hold_ready", in_ready, 1'b0);
        end
        cycle(1, 3'd2, 32'h5, 32'h3, 0, 1);
        check("bp_swap_valid", out_valid, 1'b1);
        check("bp_swap_result", result, 32'h6);
        cycle(0, 3'd0, '0, '0, 0, 1);

        // Reset in the middle of a burst
        cycle(1, 3'd6, 32'h1, 32'h0, 0, 1);
        cycle(1, 3'd6, 32'h2, 32'h0, 0, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", out_valid, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(1, 3'd1, 32'h3, 32'h0, 0, 1);
        check("midrst_result", result, 32'h3);
        check("midrst_beats", result_beats, 8'd1);
        check("midrst_valid2", out_valid, 1'b1);

        // Six-beat burst: saturates the 2-bit counter
        for (int i = 0; i < 6; i++) begin
            cycle(1, 3'd6, 32'(1) << i, 32'h0, i == 5, 1);
        end
        check("sat_result", result2, 32'h3F);
        check("sat_beats", result_beats2, 2'd3);
        check("nosat_beats", result_beats, 8'd6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? '1 : $urandom;
            cycle($urandom_range(0, 3) != 0, 3'($urandom), ra, rb,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
